// File: rtl/ysyx_bus_rarb_pkg.sv
// ysyx_bus_rarb_pkg
// Shared definitions for the read-channel arbiter: FSM state codes, AXI
// burst/size encodings, default arid values and the grant-owner type.
// No ports; imported by ysyx_bus_rarb and ysyx_bus_rarb_rstrb2size.
package ysyx_bus_rarb_pkg;

    // Arbiter FSM states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_AR_IFU = 3'd1;
    localparam logic [2:0] ST_R_IFU  = 3'd2;
    localparam logic [2:0] ST_AR_LSU = 3'd3;
    localparam logic [2:0] ST_R_LSU  = 3'd4;

    // AXI burst type and transfer-size encodings
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_1B    = 3'd0;
    localparam logic [2:0] SIZE_2B    = 3'd1;
    localparam logic [2:0] SIZE_4B    = 3'd2;
    localparam logic [2:0] SIZE_8B    = 3'd3;

    // Default AXI ids for the two requesters
    localparam logic [3:0] DEFAULT_IFU_ID = 4'd0;
    localparam logic [3:0] DEFAULT_LSU_ID = 4'd1;

    // Which requester owned the most recent grant
    typedef enum logic {
        GRANT_IFU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_e;

endpackage

// File: rtl/ysyx_bus_rarb_rstrb2size.sv
// ysyx_bus_rarb_rstrb2size
// Converts an LSU byte strobe into an AXI arsize code. Only the four
// low-aligned contiguous strobes map to their natural size; anything else
// falls back to a word access.
// Ports:
//   rstrb  in  8  LSU byte strobe
//   size   out 3  AXI arsize
module ysyx_bus_rarb_rstrb2size
    import ysyx_bus_rarb_pkg::*;
(
    input  logic [7:0] rstrb,
    output logic [2:0] size
);

    always_comb begin
        size = SIZE_4B;
        case (rstrb)
            8'h01:   size = SIZE_1B;
            8'h03:   size = SIZE_2B;
            8'h0F:   size = SIZE_4B;
            8'hFF:   size = SIZE_8B;
            default: size = SIZE_4B;
        endcase
    end

endmodule

// File: rtl/ysyx_bus_rarb.sv
// ysyx_bus_rarb
// Shares the single AXI4 master AR/R channel between the IFU (burst
// instruction refill) and the LSU (single-beat load). Handles grant
// ordering, burst framing, arsize encoding and suppression of IFU beats
// after a pipeline flush. The write path is not touched here.
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   flush                        pipeline flush, hides remaining IFU beats
//   ifu_arvalid/araddr/lock      IFU request, burst-aligned address, hold hint
//   out_ifu_ready                1-cycle pulse on IFU AR handshake
//   out_ifu_rdata/rvalid/rlast   IFU beat return
//   lsu_arvalid/araddr/rstrb     LSU load request, address, byte strobe
//   out_lsu_rdata/rvalid         LSU load return
//   out_rerr                     pulse for any granted beat with rresp != 0
//   io_master_ar*                AXI read address channel
//   io_master_r*                 AXI read data channel
module ysyx_bus_rarb
    import ysyx_bus_rarb_pkg::*;
#(
    parameter int         XLEN      = 32,
    parameter int         IFU_BEATS = 4,
    parameter logic [3:0] IFU_ID    = DEFAULT_IFU_ID,
    parameter logic [3:0] LSU_ID    = DEFAULT_LSU_ID
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,

    input  logic            ifu_arvalid,
    input  logic [XLEN-1:0] ifu_araddr,
    input  logic            ifu_lock,
    output logic            out_ifu_ready,
    output logic [XLEN-1:0] out_ifu_rdata,
    output logic            out_ifu_rvalid,
    output logic            out_ifu_rlast,

    input  logic            lsu_arvalid,
    input  logic [XLEN-1:0] lsu_araddr,
    input  logic [7:0]      lsu_rstrb,
    output logic [XLEN-1:0] out_lsu_rdata,
    output logic            out_lsu_rvalid,

    output logic            out_rerr,

    output logic            io_master_arvalid,
    output logic [XLEN-1:0] io_master_araddr,
    output logic [3:0]      io_master_arid,
    output logic [7:0]      io_master_arlen,
    output logic [2:0]      io_master_arsize,
    output logic [1:0]      io_master_arburst,
    input  logic            io_master_arready,

    input  logic            io_master_rvalid,
    input  logic [XLEN-1:0] io_master_rdata,
    input  logic [3:0]      io_master_rid,
    input  logic            io_master_rlast,
    input  logic [1:0]      io_master_rresp,
    output logic            io_master_rready
);

    localparam logic [7:0] IFU_LEN = 8'(IFU_BEATS - 1);

    logic [2:0]      state;
    grant_e          last_grant;
    logic            drop;
    logic [7:0]      beat_cnt;

    logic [XLEN-1:0] araddr_q;
    logic [3:0]      arid_q;
    logic [7:0]      arlen_q;
    logic [2:0]      arsize_q;
    logic [1:0]      arburst_q;

    logic [2:0]      lsu_size;
    logic            pick_ifu;
    logic            pick_lsu;
    logic            in_r_ifu;
    logic            in_r_lsu;
    logic            beat;
    logic            beat_done;

    ysyx_bus_rarb_rstrb2size u_rstrb2size (
        .rstrb (lsu_rstrb),
        .size  (lsu_size)
    );

    // Contention: ifu_lock pins the grant to the IFU, otherwise the side
    // that did not win last time goes first.
    always_comb begin
        pick_ifu = 1'b0;
        pick_lsu = 1'b0;
        if (ifu_arvalid && lsu_arvalid) begin
            if (ifu_lock || last_grant == GRANT_LSU) pick_ifu = 1'b1;
            else                                     pick_lsu = 1'b1;
        end else if (ifu_arvalid) begin
            pick_ifu = 1'b1;
        end else if (lsu_arvalid) begin
            pick_lsu = 1'b1;
        end
    end

    assign in_r_ifu  = (state == ST_R_IFU);
    assign in_r_lsu  = (state == ST_R_LSU);
    assign beat      = (in_r_ifu || in_r_lsu) && io_master_rvalid;
    // The beat count backs up rlast so a slave that forgets rlast cannot
    // keep the channel locked.
    assign beat_done = beat && (io_master_rlast || beat_cnt == arlen_q);

    // Grant FSM; the AR fields are captured at grant time so the requester
    // is free to drop its request afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_IFU;
            araddr_q   <= '0;
            arid_q     <= '0;
            arlen_q    <= '0;
            arsize_q   <= '0;
            arburst_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_ifu) begin
                        state      <= ST_AR_IFU;
                        last_grant <= GRANT_IFU;
                        araddr_q   <= ifu_araddr;
                        arid_q     <= IFU_ID;
                        arlen_q    <= IFU_LEN;
                        arsize_q   <= SIZE_4B;
                        arburst_q  <= BURST_INCR;
                    end else if (pick_lsu) begin
                        state      <= ST_AR_LSU;
                        last_grant <= GRANT_LSU;
                        araddr_q   <= lsu_araddr;
                        arid_q     <= LSU_ID;
                        arlen_q    <= 8'd0;
                        arsize_q   <= lsu_size;
                        arburst_q  <= BURST_INCR;
                    end
                end
                ST_AR_IFU: if (io_master_arready) state <= ST_R_IFU;
                ST_R_IFU:  if (beat_done)         state <= ST_IDLE;
                ST_AR_LSU: if (io_master_arready) state <= ST_R_LSU;
                ST_R_LSU:  if (beat_done)         state <= ST_IDLE;
                default:                          state <= ST_IDLE;
            endcase
        end
    end

    // Beat counter and flush-drop flag both clear when the burst ends, so
    // the next transaction always starts clean.
    always_ff @(posedge clock) begin
        if (reset) begin
            beat_cnt <= '0;
            drop     <= 1'b0;
        end else begin
            if (beat_done)  beat_cnt <= '0;
            else if (beat)  beat_cnt <= beat_cnt + 8'd1;

            if (beat_done)
                drop <= 1'b0;
            else if (flush && (state == ST_AR_IFU || state == ST_R_IFU))
                drop <= 1'b1;
        end
    end

    assign io_master_arvalid = (state == ST_AR_IFU) || (state == ST_AR_LSU);
    assign io_master_araddr  = araddr_q;
    assign io_master_arid    = arid_q;
    assign io_master_arlen   = arlen_q;
    assign io_master_arsize  = arsize_q;
    assign io_master_arburst = arburst_q;
    assign io_master_rready  = in_r_ifu || in_r_lsu;

    assign out_ifu_ready  = (state == ST_AR_IFU) && io_master_arready;

    // A flush in the same cycle as a beat hides it immediately; the burst
    // itself still drains on AXI.
    assign out_ifu_rvalid = in_r_ifu && io_master_rvalid && !(drop || flush);
    assign out_ifu_rlast  = out_ifu_rvalid && (io_master_rlast || beat_cnt == arlen_q);
    assign out_ifu_rdata  = in_r_ifu ? io_master_rdata : '0;

    assign out_lsu_rvalid = in_r_lsu && io_master_rvalid;
    assign out_lsu_rdata  = in_r_lsu ? io_master_rdata : '0;

    assign out_rerr = beat && (io_master_rresp != 2'b00);

    // A beat carrying the wrong id is still consumed, but it points at a
    // slave or interconnect bug.
    rid_matches_grant: assert property (@(posedge clock) disable iff (reset)
        (beat |-> io_master_rid == arid_q));

endmodule

// File: tb/tb_ysyx_bus_rarb.sv
// tb_ysyx_bus_rarb
// Directed bench for ysyx_bus_rarb. A bench-side AXI slave answers every
// AR with the requested number of beats; a transaction-level model tracks
// what the arbiter must present and a compare process checks it on every
// cycle, while the stimulus process pins key values with literals.
module tb_ysyx_bus_rarb;

    localparam int XLEN      = 32;
    localparam int IFU_BEATS = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            flush = 1'b0;
    logic            ifu_arvalid = 1'b0;
    logic [31:0]     ifu_araddr  = '0;
    logic            ifu_lock    = 1'b0;
    logic            out_ifu_ready;
    logic [31:0]     out_ifu_rdata;
    logic            out_ifu_rvalid;
    logic            out_ifu_rlast;
    logic            lsu_arvalid = 1'b0;
    logic [31:0]     lsu_araddr  = '0;
    logic [7:0]      lsu_rstrb   = '0;
    logic [31:0]     out_lsu_rdata;
    logic            out_lsu_rvalid;
    logic            out_rerr;
    logic            io_master_arvalid;
    logic [31:0]     io_master_araddr;
    logic [3:0]      io_master_arid;
    logic [7:0]      io_master_arlen;
    logic [2:0]      io_master_arsize;
    logic [1:0]      io_master_arburst;
    logic            io_master_arready = 1'b1;
    logic            io_master_rvalid  = 1'b0;
    logic [31:0]     io_master_rdata   = '0;
    logic [3:0]      io_master_rid     = '0;
    logic            io_master_rlast   = 1'b0;
    logic [1:0]      io_master_rresp   = '0;
    logic            io_master_rready;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ysyx_bus_rarb #(
        .XLEN      (XLEN),
        .IFU_BEATS (IFU_BEATS),
        .IFU_ID    (4'd0),
        .LSU_ID    (4'd1)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .flush             (flush),
        .ifu_arvalid       (ifu_arvalid),
        .ifu_araddr        (ifu_araddr),
        .ifu_lock          (ifu_lock),
        .out_ifu_ready     (out_ifu_ready),
        .out_ifu_rdata     (out_ifu_rdata),
        .out_ifu_rvalid    (out_ifu_rvalid),
        .out_ifu_rlast     (out_ifu_rlast),
        .lsu_arvalid       (lsu_arvalid),
        .lsu_araddr        (lsu_araddr),
        .lsu_rstrb         (lsu_rstrb),
        .out_lsu_rdata     (out_lsu_rdata),
        .out_lsu_rvalid    (out_lsu_rvalid),
        .out_rerr          (out_rerr),
        .io_master_arvalid (io_master_arvalid),
        .io_master_araddr  (io_master_araddr),
        .io_master_arid    (io_master_arid),
        .io_master_arlen   (io_master_arlen),
        .io_master_arsize  (io_master_arsize),
        .io_master_arburst (io_master_arburst),
        .io_master_arready (io_master_arready),
        .io_master_rvalid  (io_master_rvalid),
        .io_master_rdata   (io_master_rdata),
        .io_master_rid     (io_master_rid),
        .io_master_rlast   (io_master_rlast),
        .io_master_rresp   (io_master_rresp),
        .io_master_rready  (io_master_rready)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Strobe-to-size rule: a strobe of 2^n low bits (n in 0..3 bytes-log)
    // gives arsize n, anything else is a word.
    function automatic logic [2:0] model_size(input logic [7:0] s);
        for (int n = 0; n < 4; n++)
            if (s == 8'((1 << (1 << n)) - 1)) return 3'(n);
        return 3'd2;
    endfunction

    // Transaction-level model of the arbiter
    bit          started = 0;
    bit          m_busy = 0, m_addr_ph = 0, m_owner_lsu = 0, m_drop = 0, m_last_lsu = 0;
    int          m_beats = 0;
    logic [31:0] m_addr = '0;
    logic [7:0]  m_len = '0;
    logic [2:0]  m_size = '0;
    logic [3:0]  m_id = '0;
    logic [1:0]  m_burst = '0;

    always @(negedge clock) begin : compare
        logic data_ph, ifu_own, lsu_own, e_ifu_rv, e_ifu_rl, e_lsu_rv, e_rerr;
        bit   take_lsu;
        data_ph  = m_busy && !m_addr_ph;
        ifu_own  = data_ph && !m_owner_lsu;
        lsu_own  = data_ph && m_owner_lsu;
        e_ifu_rv = ifu_own && io_master_rvalid && !(m_drop || flush);
        e_ifu_rl = e_ifu_rv && (io_master_rlast || m_beats == int'(m_len));
        e_lsu_rv = lsu_own && io_master_rvalid;
        e_rerr   = data_ph && io_master_rvalid && (io_master_rresp != 2'b00);
        if (started) begin
            checkOutput("arvalid",   64'(io_master_arvalid), 64'(m_busy && m_addr_ph));
            checkOutput("araddr",    64'(io_master_araddr),  64'(m_addr));
            checkOutput("arid",      64'(io_master_arid),    64'(m_id));
            checkOutput("arlen",     64'(io_master_arlen),   64'(m_len));
            checkOutput("arsize",    64'(io_master_arsize),  64'(m_size));
            checkOutput("arburst",   64'(io_master_arburst), 64'(m_burst));
            checkOutput("rready",    64'(io_master_rready),  64'(data_ph));
            checkOutput("ifu_ready", 64'(out_ifu_ready),
                        64'(m_busy && m_addr_ph && !m_owner_lsu && io_master_arready));
            checkOutput("ifu_rvalid", 64'(out_ifu_rvalid), 64'(e_ifu_rv));
            checkOutput("ifu_rlast",  64'(out_ifu_rlast),  64'(e_ifu_rl));
            checkOutput("ifu_rdata",  64'(out_ifu_rdata),  64'(ifu_own ? io_master_rdata : 32'h0));
            checkOutput("lsu_rvalid", 64'(out_lsu_rvalid), 64'(e_lsu_rv));
            checkOutput("lsu_rdata",  64'(out_lsu_rdata),  64'(lsu_own ? io_master_rdata : 32'h0));
            checkOutput("rerr",       64'(out_rerr),       64'(e_rerr));
        end
        if (reset) begin
            started = 1; m_busy = 0; m_addr_ph = 0; m_owner_lsu = 0; m_drop = 0;
            m_last_lsu = 0; m_beats = 0; m_addr = '0; m_len = '0; m_size = '0;
            m_id = '0; m_burst = '0;
        end else if (started) begin
            if (!m_busy) begin
                if (ifu_arvalid || lsu_arvalid) begin
                    if (ifu_arvalid && lsu_arvalid) take_lsu = !ifu_lock && !m_last_lsu;
                    else                            take_lsu = lsu_arvalid;
                    m_busy = 1; m_addr_ph = 1; m_owner_lsu = take_lsu; m_beats = 0;
                    m_last_lsu = take_lsu; m_burst = 2'b01;
                    m_addr = take_lsu ? lsu_araddr : ifu_araddr;
                    m_len  = take_lsu ? 8'd0 : 8'(IFU_BEATS - 1);
                    m_size = take_lsu ? model_size(lsu_rstrb) : 3'd2;
                    m_id   = take_lsu ? 4'd1 : 4'd0;
                end
            end else if (m_addr_ph) begin
                if (!m_owner_lsu && flush) m_drop = 1;
                if (io_master_arready) m_addr_ph = 0;
            end else if (io_master_rvalid && (io_master_rlast || m_beats == int'(m_len))) begin
                m_busy = 0; m_drop = 0; m_beats = 0;
            end else begin
                if (io_master_rvalid) m_beats++;
                if (!m_owner_lsu && flush) m_drop = 1;
            end
        end
    end

    // Bench AXI slave: queues each accepted AR and returns its beats.
    logic [3:0]  q_id[$];
    logic [31:0] q_addr[$];
    logic [7:0]  q_len[$];
    int          s_beat = 0;
    int          cyc = 0;
    bit          rready_s = 0, reset_s = 1, slave_stall = 0, lsu_err = 0;

    always @(negedge clock) begin
        rready_s = io_master_rready;
        reset_s  = reset;
        if (!reset && io_master_arvalid && io_master_arready) begin
            q_id.push_back(io_master_arid);
            q_addr.push_back(io_master_araddr);
            q_len.push_back(io_master_arlen);
        end
    end

    always @(posedge clock) begin
        #1;
        cyc++;
        if (reset_s) begin
            q_id.delete(); q_addr.delete(); q_len.delete();
            s_beat = 0;
            io_master_rvalid = 0; io_master_rlast = 0; io_master_rdata = '0;
            io_master_rresp = '0; io_master_rid = '0;
        end else begin
            if (io_master_rvalid && rready_s) begin
                if (s_beat == int'(q_len[0])) begin
                    void'(q_id.pop_front()); void'(q_addr.pop_front()); void'(q_len.pop_front());
                    s_beat = 0;
                end else begin
                    s_beat++;
                end
            end
            if (q_id.size() > 0 && (!slave_stall || cyc[0])) begin
                io_master_rvalid = 1;
                io_master_rid    = q_id[0];
                io_master_rdata  = (q_id[0] == 4'd1) ? 32'hDEADBEEF : q_addr[0] + 32'(s_beat * 4);
                io_master_rlast  = (s_beat == int'(q_len[0]));
                io_master_rresp  = (q_id[0] == 4'd1 && lsu_err) ? 2'b10 : 2'b00;
            end else begin
                io_master_rvalid = 0; io_master_rlast = 0; io_master_rdata = '0;
                io_master_rresp = '0;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic iv, input logic [31:0] ia, input logic il,
                                 input logic lv, input logic [31:0] la,
                                 input logic [7:0] ls, input logic fl);
        ifu_arvalid = iv; ifu_araddr = ia; ifu_lock = il;
        lsu_arvalid = lv; lsu_araddr = la; lsu_rstrb = ls; flush = fl;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        @(negedge clock);
        while (m_busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (m_busy) begin
            checks++; errors++;
            $display("[TB] FAIL idle_timeout: still busy after %0d cycles, required idle", budget);
        end
        step();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int beats, last_at, ab, ib;
        logic [31:0] d1, d4;
        bit flushed;

        $display("[TB] starting");
        idleInputs();
        repeat (3) step();
        reset = 0;

        // Reset state straight after release
        @(negedge clock);
        checkOutput("reset_arvalid", 64'(io_master_arvalid), 64'd0);
        checkOutput("reset_arburst", 64'(io_master_arburst), 64'd0);
        checkOutput("reset_rready",  64'(io_master_rready),  64'd0);
        step();

        // Contention from reset, no lock: LSU wins first
        applyStimulus(1'b1, 32'h3000_0040, 1'b0, 1'b1, 32'h8000_0020, 8'h03, 1'b0);
        step();
        idleInputs();
        @(negedge clock);
        checkOutput("cont1_arid",   64'(io_master_arid),   64'd1);
        checkOutput("cont1_arsize", 64'(io_master_arsize), 64'd1);
        waitIdle(20);

        // Repeat contention: IFU's turn
        applyStimulus(1'b1, 32'h3000_0080, 1'b0, 1'b1, 32'h8000_0024, 8'h0F, 1'b0);
        step();
        idleInputs();
        @(negedge clock);
        checkOutput("cont2_arid", 64'(io_master_arid), 64'd0);
        waitIdle(20);

        // Lock holds IFU even though it won last
        applyStimulus(1'b1, 32'h3000_00C0, 1'b1, 1'b1, 32'h8000_0028, 8'hFF, 1'b0);
        step();
        idleInputs();
        @(negedge clock);
        checkOutput("lock_arid", 64'(io_master_arid), 64'd0);
        waitIdle(20);

        // LSU lw alone
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0010, 8'h0F, 1'b0);
        step();
        idleInputs();
        @(negedge clock);
        checkOutput("lw_arvalid", 64'(io_master_arvalid), 64'd1);
        checkOutput("lw_araddr",  64'(io_master_araddr),  64'h8000_0010);
        checkOutput("lw_arsize",  64'(io_master_arsize),  64'd2);
        checkOutput("lw_arlen",   64'(io_master_arlen),   64'd0);
        checkOutput("lw_arid",    64'(io_master_arid),    64'd1);
        step();
        @(negedge clock);
        checkOutput("lw_rvalid", 64'(out_lsu_rvalid), 64'd1);
        checkOutput("lw_rdata",  64'(out_lsu_rdata),  64'hDEADBEEF);
        waitIdle(20);

        // IFU burst with a stalling slave
        slave_stall = 1;
        applyStimulus(1'b1, 32'h3000_0000, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
        step();
        idleInputs();
        @(negedge clock);
        checkOutput("ifu_arlen",   64'(io_master_arlen),   64'd3);
        checkOutput("ifu_arburst", 64'(io_master_arburst), 64'd1);
        checkOutput("ifu_ready_pulse", 64'(out_ifu_ready), 64'd1);
        beats = 0; last_at = 0; d1 = '0; d4 = '0;
        for (int k = 0; k < 24 && m_busy; k++) begin
            step();
            @(negedge clock);
            if (out_ifu_rvalid) begin
                beats++;
                if (beats == 1) d1 = out_ifu_rdata;
                if (beats == 4) d4 = out_ifu_rdata;
                if (out_ifu_rlast) last_at = beats;
            end
        end
        checkOutput("ifu_beats",   64'(beats),   64'd4);
        checkOutput("ifu_rlast_at", 64'(last_at), 64'd4);
        checkOutput("ifu_beat1",   64'(d1), 64'h3000_0000);
        checkOutput("ifu_beat4",   64'(d4), 64'h3000_000C);
        slave_stall = 0;
        waitIdle(20);

        // Flush after the first IFU beat
        applyStimulus(1'b1, 32'h3000_0100, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
        step();
        idleInputs();
        ab = 0; ib = 0; flushed = 0;
        for (int k = 0; k < 24 && m_busy; k++) begin
            step();
            flush = (ib == 1 && !flushed);
            if (flush) flushed = 1;
            @(negedge clock);
            if (io_master_rvalid && io_master_rready) ab++;
            if (out_ifu_rvalid) ib++;
        end
        checkOutput("flush_axi_beats", 64'(ab), 64'd4);
        checkOutput("flush_ifu_beats", 64'(ib), 64'd1);
        waitIdle(20);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0100, 8'h01, 1'b0);
        step();
        idleInputs();
        step();
        @(negedge clock);
        checkOutput("post_flush_lsu_rvalid", 64'(out_lsu_rvalid), 64'd1);
        waitIdle(20);

        // Slow arready: arvalid must hold
        io_master_arready = 0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0200, 8'h05, 1'b0);
        step();
        idleInputs();
        step();
        @(negedge clock);
        checkOutput("hold_arvalid", 64'(io_master_arvalid), 64'd1);
        checkOutput("odd_strb_size", 64'(io_master_arsize), 64'd2);
        step();
        io_master_arready = 1;
        waitIdle(20);

        // Error response on an LSU beat
        lsu_err = 1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0300, 8'h0F, 1'b0);
        step();
        idleInputs();
        step();
        @(negedge clock);
        checkOutput("rerr_pulse", 64'(out_rerr), 64'd1);
        step();
        @(negedge clock);
        checkOutput("rerr_clear", 64'(out_rerr), 64'd0);
        lsu_err = 0;
        waitIdle(20);

        // Reset in the middle of an IFU burst
        applyStimulus(1'b1, 32'h3000_0200, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
        step();
        idleInputs();
        step();
        reset = 1;
        step();
        reset = 0;
        @(negedge clock);
        checkOutput("rst_arvalid", 64'(io_master_arvalid), 64'd0);
        checkOutput("rst_rready",  64'(io_master_rready),  64'd0);
        checkOutput("rst_ifu_rv",  64'(out_ifu_rvalid),    64'd0);
        checkOutput("rst_araddr",  64'(io_master_araddr),  64'd0);
        checkOutput("rst_arburst", 64'(io_master_arburst), 64'd0);
        step();

        // After reset contention again favours the LSU
        applyStimulus(1'b1, 32'h3000_0300, 1'b0, 1'b1, 32'h8000_0400, 8'h0F, 1'b0);
        step();
        idleInputs();
        @(negedge clock);
        checkOutput("rst_cont_arid", 64'(io_master_arid), 64'd1);
        waitIdle(20);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
